// File: rtl/dp_feeder_pkg.sv
// Shared types and widths for the dot-product engine feeder.
// The engine bus is fixed at 32 lanes of 4-bit nibbles (128 bits) and a 13-bit result.
package dp_feeder_pkg;

  localparam int NIB_W      = 4;
  localparam int VEC_W      = 128;
  localparam int RES_W      = 13;
  localparam int BEAT_CNT_W = 5;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dp_vec_packer.sv
// Beat counter plus nibble-indexed writes into the I/W vector registers.
// Beat k lands in bits [127-4k -: 4]; weight writes are gated by w_en.
module dp_vec_packer
  import dp_feeder_pkg::*;
#(
  parameter int NIBBLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_fire,
  input  logic             w_en,
  input  logic [NIB_W-1:0] nib_i,
  input  logic [NIB_W-1:0] nib_w,
  output logic [VEC_W-1:0] vec_i,
  output logic [VEC_W-1:0] vec_w,
  output logic             first_beat,
  output logic             last_beat
);

  logic [BEAT_CNT_W-1:0] count;

  assign first_beat = (count == '0);
  assign last_beat  = (count == BEAT_CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (beat_fire) begin
      count <= last_beat ? '0 : count + 1'b1;
    end
  end

  // Vectors hold between beats so the engine sees stable data after ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_i <= '0;
      vec_w <= '0;
    end else if (beat_fire) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (count == BEAT_CNT_W'(k)) begin
          vec_i[VEC_W-1-NIB_W*k -: NIB_W] <= nib_i;
          if (w_en) begin
            vec_w[VEC_W-1-NIB_W*k -: NIB_W] <= nib_w;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dot_product_feeder.sv
// Initiator-side driver for the 32-lane 4-bit dot-product engine: packs host beats,
// strobes the engine, waits for its result with a timeout and returns it to the host.
module dot_product_feeder
  import dp_feeder_pkg::*;
#(
  parameter int NIBBLES = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [NIB_W-1:0] s_i,
  input  logic [NIB_W-1:0] s_w,
  input  logic             s_reuse_w,
  output logic             eng_in_valid,
  output logic             eng_weight_valid,
  output logic [VEC_W-1:0] eng_I,
  output logic [VEC_W-1:0] eng_W,
  input  logic             eng_out_valid,
  input  logic [RES_W-1:0] eng_OUT,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [RES_W-1:0] r_data,
  output logic             r_timeout,
  output logic             err_stray
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Handshakes: a beat moves when s_valid && s_ready at a rising edge; a result
  // moves when r_valid && r_ready. Both ready/valid outputs are registered.

  state_t               state, state_d;
  logic [TIMER_W-1:0]   timer;
  logic                 reuse_lat;
  logic                 w_loaded;
  logic                 beat_fire;
  logic                 reuse_now;
  logic                 w_en;
  logic                 first_beat;
  logic                 last_beat;
  logic                 timeout_hit;

  assign beat_fire   = s_valid && s_ready;
  assign reuse_now   = s_reuse_w && w_loaded;
  // Beat 0 decides reuse for the whole vector before reuse_lat has updated.
  assign w_en        = first_beat ? !reuse_now : !reuse_lat;
  assign timeout_hit = (timer == TIMER_W'(TIMEOUT - 1));

  dp_vec_packer #(
    .NIBBLES (NIBBLES)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_fire  (beat_fire),
    .w_en       (w_en),
    .nib_i      (s_i),
    .nib_w      (s_w),
    .vec_i      (eng_I),
    .vec_w      (eng_W),
    .first_beat (first_beat),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      LOAD:  if (beat_fire && last_beat) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (eng_out_valid || timeout_hit) state_d = RESP;
      RESP:  if (r_valid && r_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Strobes and ready/valid follow the next state so each is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready          <= 1'b0;
      eng_in_valid     <= 1'b0;
      eng_weight_valid <= 1'b0;
      r_valid          <= 1'b0;
    end else begin
      s_ready          <= (state_d == LOAD);
      eng_in_valid     <= (state_d == ISSUE);
      eng_weight_valid <= (state_d == ISSUE) && !reuse_lat;
      r_valid          <= (state_d == RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_lat <= 1'b0;
      w_loaded  <= 1'b0;
    end else begin
      if (beat_fire && first_beat) begin
        reuse_lat <= reuse_now;
      end
      if (eng_weight_valid) begin
        w_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT) begin
      timer <= timer + 1'b1;
    end
  end

  // A real result beats a timeout that lands on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_timeout <= 1'b0;
    end else if (state == WAIT) begin
      if (eng_out_valid) begin
        r_data    <= eng_OUT;
        r_timeout <= 1'b0;
      end else if (timeout_hit) begin
        r_data    <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stray <= 1'b0;
    end else if (eng_out_valid && (state != WAIT)) begin
      err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder with a behavioural engine model that keeps
// its own weight register and answers a fixed number of cycles after each strobe.
module tb_dot_product_feeder;

  localparam int TIMEOUT = 16;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [3:0]   s_i;
  logic [3:0]   s_w;
  logic         s_reuse_w;
  logic         eng_in_valid;
  logic         eng_weight_valid;
  logic [127:0] eng_I;
  logic [127:0] eng_W;
  logic         eng_out_valid;
  logic [12:0]  eng_OUT;
  logic         r_valid;
  logic         r_ready;
  logic [12:0]  r_data;
  logic         r_timeout;
  logic         err_stray;

  int total;
  int bad;

  // engine model controls and drive
  logic         model_valid;
  logic [12:0]  model_out;
  logic         stray_pulse;
  logic [12:0]  stray_data;
  logic [127:0] eng_wreg;
  int           eng_lat;
  bit           eng_silent;
  int           n_in;
  int           n_wv;

  assign eng_out_valid = model_valid | stray_pulse;
  assign eng_OUT       = stray_pulse ? stray_data : model_out;

  dot_product_feeder #(
    .NIBBLES (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_i              (s_i),
    .s_w              (s_w),
    .s_reuse_w        (s_reuse_w),
    .eng_in_valid     (eng_in_valid),
    .eng_weight_valid (eng_weight_valid),
    .eng_I            (eng_I),
    .eng_W            (eng_W),
    .eng_out_valid    (eng_out_valid),
    .eng_OUT          (eng_OUT),
    .r_valid          (r_valid),
    .r_ready          (r_ready),
    .r_data           (r_data),
    .r_timeout        (r_timeout),
    .err_stray        (err_stray)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] dot(input logic [127:0] a, input logic [127:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 32; k++) s += int'(a[4*k+3 -: 4]) * int'(b[4*k+3 -: 4]);
    return 13'(s);
  endfunction

  // engine model: strobe seen at negedge N0, result driven at negedge N(eng_lat)
  initial begin
    model_valid = 1'b0;
    model_out   = '0;
    eng_wreg    = '0;
    forever begin
      @(negedge clk);
      if (eng_in_valid === 1'b1) begin
        logic [12:0] acc;
        if (eng_weight_valid === 1'b1) eng_wreg = eng_W;
        acc = dot(eng_I, eng_wreg);
        if (!eng_silent) begin
          repeat (eng_lat) @(negedge clk);
          model_valid = 1'b1;
          model_out   = acc;
          @(negedge clk);
          model_valid = 1'b0;
          model_out   = '0;
        end
      end
    end
  end

  // strobe counters, read as before/after differences
  initial begin
    n_in = 0;
    n_wv = 0;
    forever begin
      @(negedge clk);
      if (eng_in_valid === 1'b1) n_in++;
      if (eng_weight_valid === 1'b1) n_wv++;
    end
  end

  // driver: send nbeats beats from packed vectors; returns at the negedge after the last beat
  task automatic send_vec(input logic [127:0] iv, input logic [127:0] wv,
                          input logic reuse, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int guard;
      s_valid   = 1'b1;
      s_i       = iv[127-4*k -: 4];
      s_w       = wv[127-4*k -: 4];
      s_reuse_w = reuse;
      guard     = 0;
      while (s_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        total++;
        bad++;
        $display("FAIL send_beat_timeout: beat %0d s_ready=%b required 1", k, s_ready);
      end
      @(negedge clk);
    end
    s_valid   = 1'b0;
    s_reuse_w = 1'b0;
  endtask

  // driver: wait for r_valid (counting negedges), capture it, then complete the handshake
  task automatic get_result(output logic [12:0] d, output logic to, output int cycles);
    cycles = 0;
    while (r_valid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (r_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL result_wait_timeout: r_valid=%b required 1", r_valid);
    end
    d       = r_data;
    to      = r_timeout;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, eng_in_valid, eng_weight_valid, r_valid, r_timeout, err_stray} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {s_ready, eng_in_valid, eng_weight_valid, r_valid, r_timeout, err_stray});
    end
    total++;
    if (eng_I !== '0 || eng_W !== '0 || r_data !== '0) begin
      bad++;
      $display("FAIL reset_data: eng_I=%h eng_W=%h r_data=%h required all 0", eng_I, eng_W, r_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: s_ready=%b required 1", s_ready);
    end
  endtask

  // all-ones vector, with reuse requested on the first vector after reset (must be ignored)
  task automatic test_all_ones_first_reuse();
    logic [12:0] d;
    logic        to;
    int          cyc, in0, wv0;
    in0 = n_in;
    wv0 = n_wv;
    eng_lat = 5;
    send_vec({32{4'h1}}, {32{4'h1}}, 1'b1, 32);
    total++;
    if (eng_I !== {32{4'h1}} || eng_W !== {32{4'h1}}) begin
      bad++;
      $display("FAIL ones_vectors: eng_I=%h eng_W=%h required all 1", eng_I, eng_W);
    end
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL ones_ready_drop: s_ready=%b required 0", s_ready);
    end
    get_result(d, to, cyc);
    total++;
    if (d !== 13'd32 || to !== 1'b0) begin
      bad++;
      $display("FAIL ones_result: r_data=%0d r_timeout=%b required 32 0", d, to);
    end
    total++;
    if (n_in - in0 != 1 || n_wv - wv0 != 1) begin
      bad++;
      $display("FAIL ones_strobes: in_valid=%0d weight_valid=%0d required 1 1", n_in - in0, n_wv - wv0);
    end
    total++;
    if (cyc != 6) begin
      bad++;
      $display("FAIL ones_latency: cycles=%0d required 6", cyc);
    end
  endtask

  task automatic test_max_values();
    logic [12:0] d;
    logic        to;
    int          cyc;
    send_vec({32{4'hF}}, {32{4'hF}}, 1'b0, 32);
    total++;
    if (eng_I !== {32{4'hF}} || eng_W !== {32{4'hF}}) begin
      bad++;
      $display("FAIL max_vectors: eng_I=%h eng_W=%h required all F", eng_I, eng_W);
    end
    get_result(d, to, cyc);
    total++;
    if (d !== 13'h1C20 || to !== 1'b0) begin
      bad++;
      $display("FAIL max_result: r_data=%h r_timeout=%b required 1c20 0", d, to);
    end
  endtask

  task automatic test_pattern();
    logic [12:0] d;
    logic        to;
    int          cyc;
    send_vec({2{64'h0123456789ABCDEF}}, {32{4'h1}}, 1'b0, 32);
    total++;
    if (eng_I !== {2{64'h0123456789ABCDEF}}) begin
      bad++;
      $display("FAIL pattern_order: eng_I=%h required 0123..ef0123..ef", eng_I);
    end
    get_result(d, to, cyc);
    total++;
    if (d !== 13'd240) begin
      bad++;
      $display("FAIL pattern_result: r_data=%0d required 240", d);
    end
  endtask

  task automatic test_weight_reuse();
    logic [12:0] d;
    logic        to;
    int          cyc, wv0;
    send_vec({32{4'h1}}, {32{4'h2}}, 1'b0, 32);
    get_result(d, to, cyc);
    total++;
    if (d !== 13'd64) begin
      bad++;
      $display("FAIL reuse_a_result: r_data=%0d required 64", d);
    end
    wv0 = n_wv;
    send_vec({32{4'h1}}, {32{4'h7}}, 1'b1, 32);
    total++;
    if (eng_W !== {32{4'h2}}) begin
      bad++;
      $display("FAIL reuse_b_weights: eng_W=%h required all 2", eng_W);
    end
    get_result(d, to, cyc);
    total++;
    if (n_wv - wv0 != 0) begin
      bad++;
      $display("FAIL reuse_b_weight_valid: pulses=%0d required 0", n_wv - wv0);
    end
    total++;
    if (d !== 13'd64) begin
      bad++;
      $display("FAIL reuse_b_result: r_data=%0d required 64", d);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] d;
    logic        to;
    int          cyc;
    eng_silent = 1'b1;
    send_vec({32{4'h1}}, {32{4'h1}}, 1'b0, 32);
    get_result(d, to, cyc);
    eng_silent = 1'b0;
    total++;
    if (d !== 13'd0 || to !== 1'b1) begin
      bad++;
      $display("FAIL timeout_result: r_data=%0d r_timeout=%b required 0 1", d, to);
    end
    // ISSUE cycle plus TIMEOUT cycles of WAIT before r_valid appears
    total++;
    if (cyc != TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", cyc, TIMEOUT + 1);
    end
    eng_lat = TIMEOUT;
    send_vec({32{4'h1}}, {32{4'h1}}, 1'b0, 32);
    get_result(d, to, cyc);
    eng_lat = 5;
    total++;
    if (d !== 13'd32 || to !== 1'b0 || cyc != TIMEOUT + 1) begin
      bad++;
      $display("FAIL coincident_result: r_data=%0d r_timeout=%b cycles=%0d required 32 0 %0d",
               d, to, cyc, TIMEOUT + 1);
    end
    total++;
    if (err_stray !== 1'b0) begin
      bad++;
      $display("FAIL coincident_no_stray: err_stray=%b required 0", err_stray);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    send_vec({32{4'h2}}, {32{4'h3}}, 1'b0, 32);
    cyc = 0;
    while (r_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (r_valid !== 1'b1 || r_data !== 13'd192 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: r_valid=%b r_data=%0d s_ready=%b required 1 192 0",
                 c, r_valid, r_data, s_ready);
      end
      if (c == 2) begin
        stray_data  = 13'h1ABC;
        stray_pulse = 1'b1;
      end else begin
        stray_pulse = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (err_stray !== 1'b1 || r_data !== 13'd192) begin
      bad++;
      $display("FAIL bp_stray: err_stray=%b r_data=%0d required 1 192", err_stray, r_data);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    total++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: r_valid=%b s_ready=%b required 0 1", r_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [12:0] d;
    logic        to;
    int          cyc, in0, wv0;
    send_vec({32{4'hF}}, {32{4'hF}}, 1'b0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (eng_I !== '0 || eng_W !== '0 || err_stray !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: eng_I=%h eng_W=%h err_stray=%b required 0 0 0",
               eng_I, eng_W, err_stray);
    end
    rst_n = 1'b1;
    @(negedge clk);
    in0 = n_in;
    wv0 = n_wv;
    send_vec({32{4'h3}}, {32{4'h1}}, 1'b0, 32);
    total++;
    if (eng_I !== {32{4'h3}} || eng_W !== {32{4'h1}}) begin
      bad++;
      $display("FAIL midreset_vectors: eng_I=%h eng_W=%h required all 3 / all 1", eng_I, eng_W);
    end
    get_result(d, to, cyc);
    total++;
    if (d !== 13'd96 || to !== 1'b0) begin
      bad++;
      $display("FAIL midreset_result: r_data=%0d r_timeout=%b required 96 0", d, to);
    end
    total++;
    if (n_in - in0 != 1 || n_wv - wv0 != 1) begin
      bad++;
      $display("FAIL midreset_issues: in_valid=%0d weight_valid=%0d required 1 1",
               n_in - in0, n_wv - wv0);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_i         = '0;
    s_w         = '0;
    s_reuse_w   = 1'b0;
    r_ready     = 1'b0;
    stray_pulse = 1'b0;
    stray_data  = '0;
    eng_lat     = 5;
    eng_silent  = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_ones_first_reuse();
    test_max_values();
    test_pattern();
    test_weight_reuse();
    test_timeout();
    test_backpressure();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
